// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM state type and request legality check shared by the load/store unit.
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

    // Encoding and alignment errors only; the range check depends on MEM_SIZE and lives in the top.
    function automatic logic f3_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
        return f3 == 3'b011 || f3[2:1] == 2'b11 || (we && f3[2]) ||
               ((f3 == F3_H || f3 == F3_HU) && off[0]) || (f3 == F3_W && off != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian lane extract/extend for loads and lane merge for sub-word stores.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       funct3,
    input  logic [1:0]       offset,
    input  logic [WIDTH-1:0] word,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] store_data
);
    logic [4:0]       sh;
    logic [15:0]      lane;
    logic [WIDTH-1:0] mask;

    always_comb begin
        sh = {offset, 3'b000};
        lane = 16'(word >> sh);
        mask = funct3[1:0] == 2'b00 ? WIDTH'(8'hFF) : funct3[1:0] == 2'b01 ? WIDTH'(16'hFFFF) : '1;
        load_data = funct3 == F3_B  ? {{(WIDTH-8){lane[7]}}, lane[7:0]} :
                    funct3 == F3_BU ? {{(WIDTH-8){1'b0}}, lane[7:0]} :
                    funct3 == F3_H  ? {{(WIDTH-16){lane[15]}}, lane} :
                    funct3 == F3_HU ? {{(WIDTH-16){1'b0}}, lane} : word;
        store_data = (word & ~(mask << sh)) | ((wdata << sh) & (mask << sh));
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store FSM driving a word-wide data memory,
// with read-modify-write for byte/halfword stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MEM_SIZE = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [2:0]       req_funct3,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             rsp_err,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_re,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_wr,
    output logic [WIDTH-1:0] mem_wdata
);
    state_t           state;
    logic             we_q, err_q, req_err;
    logic [2:0]       f3_q;
    logic [WIDTH-1:0] addr_q, wdata_q, rdata_q, load_data, store_data;

    assign req_err = f3_err(req_we, req_funct3, req_addr[1:0]) || (req_addr >> 2) >= WIDTH'(MEM_SIZE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (state == IDLE && req_valid) begin
            we_q    <= req_we;
            err_q   <= req_err;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            state   <= req_err ? RSP : (req_we && req_funct3 == F3_W) ? WR : RD;
        end else if (state == RD) begin
            rdata_q <= mem_rdata;
            state   <= we_q ? WR : RSP;
        end else begin
            state <= state == WR ? RSP : IDLE;
        end
    end

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .funct3     (f3_q),
        .offset     (addr_q[1:0]),
        .word       (rdata_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // Word stores skip RD; the all-ones lane mask makes the merge pass wdata straight through.
    assign req_ready = state == IDLE;
    assign mem_re    = state == RD;
    assign mem_wr    = state == WR;
    assign mem_addr  = (mem_re || mem_wr) ? {addr_q[WIDTH-1:2], 2'b00} : '0;
    assign mem_wdata = mem_wr ? store_data : '0;
    assign rsp_valid = state == RSP;
    assign rsp_err   = rsp_valid && err_q;
    assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? load_data : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random requests checked every cycle against a byte-level memory model.
module tb_load_store_unit;
    logic        clk = 0, reset = 1, req_valid = 0, req_we = 0;
    logic        req_ready, rsp_valid, rsp_err, mem_re, mem_wr;
    logic [2:0]  req_funct3 = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata, mem_addr, mem_rdata, mem_wdata;
    logic [31:0] mem [1024];
    logic [7:0]  ref_b [4096];
    int checks = 0, errors = 0, re_cnt = 0, wr_cnt = 0;
    logic [31:0] last_wdata, last_waddr;
    bit started = 0;

    typedef struct {
        logic        err;
        logic [31:0] base, rdata, wword;
        int          lat, rd_k, wr_k;
    } txn_t;
    txn_t t;
    bit busy = 0;
    int k = 0;

    load_store_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_wr(mem_wr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_wr) mem[mem_addr[11:2]] <= mem_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic txn_t predict(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        txn_t r;
        int sz;
        logic [7:0] w [4];
        sz = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
        r.err = f3[1:0] == 2'b11 || f3[2:1] == 2'b11 || (we && f3[2]) || (a % sz) != 0 || (a / 4) >= 1024;
        r.base = a & ~32'd3;
        r.rdata = 0;
        r.wword = 0;
        r.rd_k = 0;
        r.wr_k = 0;
        r.lat = 1;
        if (!r.err) begin
            for (int i = 0; i < 4; i++) w[i] = ref_b[r.base + i];
            if (!we) begin
                for (int i = 0; i < sz; i++) r.rdata |= 32'(w[a[1:0] + i]) << (8 * i);
                if (!f3[2] && sz < 4 && r.rdata[8*sz-1]) r.rdata |= 32'hFFFF_FFFF << (8 * sz);
                r.rd_k = 1;
                r.lat = 2;
            end else begin
                for (int i = 0; i < sz; i++) w[a[1:0] + i] = d[8*i +: 8];
                r.wword = {w[3], w[2], w[1], w[0]};
                r.rd_k = sz == 4 ? 0 : 1;
                r.wr_k = sz == 4 ? 1 : 2;
                r.lat = r.wr_k + 1;
            end
        end
        return r;
    endfunction

    always @(negedge clk) if (started) begin
        logic e_re, e_wr, e_rv;
        e_re = busy && k == t.rd_k;
        e_wr = busy && k == t.wr_k;
        e_rv = busy && k == t.lat;
        chk("req_ready", req_ready, !busy);
        chk("mem_re", mem_re, e_re);
        chk("mem_wr", mem_wr, e_wr);
        chk("mem_addr", mem_addr, (e_re || e_wr) ? t.base : 0);
        chk("mem_wdata", mem_wdata, e_wr ? t.wword : 0);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_err", rsp_err, e_rv && t.err);
        chk("rsp_rdata", rsp_rdata, e_rv ? t.rdata : 0);
        if (mem_re) re_cnt++;
        if (mem_wr) begin
            wr_cnt++;
            last_wdata = mem_wdata;
            last_waddr = mem_addr;
        end
        if (e_wr) for (int i = 0; i < 4; i++) ref_b[t.base + i] = t.wword[8*i +: 8];
        if (reset) busy = 0;
        else if (busy) begin
            if (k == t.lat) busy = 0;
            else k++;
        end else if (req_valid) begin
            t = predict(req_we, req_funct3, req_addr, req_wdata);
            busy = 1;
            k = 1;
        end
    end

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er, output int lat);
        int n = 0;
        @(posedge clk); #1;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (n == 20) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 10) begin @(posedge clk); #1; lat++; end
        if (!rsp_valid) chk("rsp_timeout", 0, 1);
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    task automatic dir(input string name, input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_er, input int exp_lat,
                       input int exp_re, input int exp_wr);
        logic [31:0] rd;
        logic er;
        int lat, re0, wr0;
        re0 = re_cnt;
        wr0 = wr_cnt;
        run(we, f3, a, d, rd, er, lat);
        chk({name, "_rdata"}, rd, exp_rd);
        chk({name, "_err"}, 32'(er), 32'(exp_er));
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_re"}, re_cnt - re0, exp_re);
        chk({name, "_wr"}, wr_cnt - wr0, exp_wr);
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        int lat, n, wr0;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom;
            for (int j = 0; j < 4; j++) ref_b[4*i + j] = mem[i][8*j +: 8];
        end
        repeat (3) @(posedge clk);
        #1 started = 1;
        chk("reset_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_mem_addr", mem_addr, 0);
        reset = 0;

        dir("sw100", 1, 3'b010, 32'h100, 32'h80818283, 0, 0, 2, 0, 1);
        chk("sw100_addr", last_waddr, 32'h100);
        dir("lw100", 0, 3'b010, 32'h100, 0, 32'h80818283, 0, 2, 1, 0);
        dir("lb101", 0, 3'b000, 32'h101, 0, 32'hFFFFFF82, 0, 2, 1, 0);
        dir("lbu103", 0, 3'b100, 32'h103, 0, 32'h00000080, 0, 2, 1, 0);
        dir("lh102", 0, 3'b001, 32'h102, 0, 32'hFFFF8081, 0, 2, 1, 0);
        dir("sh102", 1, 3'b001, 32'h102, 32'hABCD1234, 0, 0, 3, 1, 1);
        chk("sh102_wdata", last_wdata, 32'h12348283);
        dir("lw102", 0, 3'b010, 32'h102, 0, 0, 1, 1, 0, 0);
        dir("lh101", 0, 3'b001, 32'h101, 0, 0, 1, 1, 0, 0);
        dir("lw1000", 0, 3'b010, 32'h1000, 0, 0, 1, 1, 0, 0);
        dir("f3_011", 0, 3'b011, 32'h100, 0, 0, 1, 1, 0, 0);
        dir("sbu", 1, 3'b100, 32'h100, 0, 0, 1, 1, 0, 0);

        // Reset lands while the SB read-modify-write is in its read cycle.
        wr0 = wr_cnt;
        @(posedge clk); #1;
        req_valid = 1; req_we = 1; req_funct3 = 3'b000; req_addr = 32'h104; req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 0;
        chk("sb_rst_in_rd", mem_re, 1);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        n = 0;
        repeat (5) begin
            if (rsp_valid) n++;
            @(posedge clk); #1;
        end
        chk("sb_rst_no_rsp", n, 0);
        chk("sb_rst_no_wr", wr_cnt - wr0, 0);
        chk("sb_rst_ready", req_ready, 1);

        // Back-to-back with req_valid held high.
        @(posedge clk); #1;
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h100;
        @(posedge clk); #1;
        req_funct3 = 3'b101; req_addr = 32'h102;
        n = 0;
        while (!rsp_valid && n < 10) begin
            chk("b2b_busy_ready", req_ready, 0);
            @(posedge clk); #1; n++;
        end
        chk("b2b_first_rdata", rsp_rdata, 32'h12348283);
        chk("b2b_rsp_ready", req_ready, 0);
        @(posedge clk); #1;
        chk("b2b_ready_after_rsp", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 0;
        n = 0;
        while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
        chk("b2b_second_rdata", rsp_rdata, 32'h00001234);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 15) == 0) ? 32'h1000 + $urandom_range(0, 255) : $urandom_range(0, 63);
            run(1'($urandom), 3'($urandom), a, $urandom, rd, er, lat);
        end
        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
